// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the push-button debouncer.
//   - db_state_e      : FSM state encoding (REL, ARM_P, PRS, ARM_R)
//   - CLK_HZ          : board system clock frequency
//   - DEBOUNCE_MS     : default debounce window in milliseconds
//   - DEFAULT_STABLE  : debounce window expressed in clock cycles
//   - norm_sample()   : maps a raw synchronised pin value to 1 = pressed
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        REL   = 2'd0,   // settled released
        ARM_P = 2'd1,   // candidate press, counting stable cycles
        PRS   = 2'd2,   // settled pressed
        ARM_R = 2'd3    // candidate release, counting stable cycles
    } db_state_e;

    localparam int unsigned CLK_HZ         = 32'd50000000;
    localparam int unsigned DEBOUNCE_MS    = 32'd20;
    localparam int unsigned DEFAULT_STABLE = (CLK_HZ / 32'd1000) * DEBOUNCE_MS;

    // Active-low buttons read 0 when pressed; XOR folds both polarities into
    // a single "1 = pressed" view so the FSM never has to care.
    function automatic logic norm_sample(input logic raw, input logic active_low);
        return raw ^ active_low;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input bit.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, both flops load RST_VAL
//   d_i  - asynchronous input
//   q_o  - synchronised output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability-resolving flop chain; resets to the idle pin level so no
    // phantom edge is seen when reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Cleans one raw, bouncing push-button pin into a stable level and one-cycle
// event strobes (press, release, long-hold).
// Ports:
//   clk         - system clock
//   rst         - asynchronous active-high reset
//   btn_in      - raw button pin, asynchronous to clk
//   btn_level   - debounced level, 1 = pressed
//   press_stb   - one-cycle pulse when a press is accepted
//   release_stb - one-cycle pulse when a release is accepted
//   long_stb    - one-cycle pulse once per press after LONG_CYCLES of hold
// All outputs are registered.
// -----------------------------------------------------------------------------
module key_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE,
    parameter int unsigned LONG_CYCLES   = 32'd50000000,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned CNT_W         = 32'd27
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_stb,
    output logic release_stb,
    output logic long_stb
);

    localparam logic [63:0] LONG_M1 = 64'(LONG_CYCLES) - 64'd1;

    // Reject parameter sets the counters cannot represent.
    generate
        if (STABLE_CYCLES < 32'd2) begin : g_bad_stable
            $error("key_debounce: STABLE_CYCLES must be >= 2");
        end
        if (LONG_CYCLES <= STABLE_CYCLES) begin : g_bad_long
            $error("key_debounce: LONG_CYCLES must exceed STABLE_CYCLES");
        end
        if ((LONG_M1 >> CNT_W) != 64'd0) begin : g_bad_width
            $error("key_debounce: CNT_W too narrow to hold LONG_CYCLES-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 32'd1);

    logic             sync_s;
    logic             pressed_s;
    logic             press_evt_s;
    logic             release_evt_s;
    logic [CNT_W-1:0] stab_d;
    logic [CNT_W-1:0] hold_d;

    db_state_e        state_q;
    logic [CNT_W-1:0] stab_q;
    logic [CNT_W-1:0] hold_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic             long_done_q;

    sync_2ff #(
        .RST_VAL (logic'(ACTIVE_LOW))
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_in),
        .q_o (sync_s)
    );

    assign pressed_s = norm_sample(sync_s, logic'(ACTIVE_LOW));

    // Acceptance happens on the cycle the last required stable sample is seen.
    assign press_evt_s   = (state_q == ARM_P) && pressed_s  && (stab_q == STAB_LAST);
    assign release_evt_s = (state_q == ARM_R) && !pressed_s && (stab_q == STAB_LAST);

    assign stab_d = stab_q + CNT_ONE;
    // Hold counter saturates so it cannot wrap and re-fire long_stb.
    assign hold_d = (hold_q == HOLD_LAST) ? hold_q : (hold_q + CNT_ONE);

    // Debounce FSM, stability/hold counters and registered output strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= REL;
            stab_q      <= CNT_ZERO;
            hold_q      <= CNT_ZERO;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            long_done_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            case (state_q)
                REL: begin
                    level_q <= 1'b0;
                    if (pressed_s) begin
                        state_q <= ARM_P;
                        stab_q  <= CNT_ONE;
                    end else begin
                        stab_q  <= CNT_ZERO;
                    end
                end
                ARM_P: begin
                    if (!pressed_s) begin
                        state_q <= REL;
                        stab_q  <= CNT_ZERO;
                    end else if (press_evt_s) begin
                        state_q <= PRS;
                        stab_q  <= CNT_ZERO;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        stab_q  <= stab_d;
                    end
                end
                PRS: begin
                    level_q <= 1'b1;
                    if (!pressed_s) begin
                        state_q <= ARM_R;
                        stab_q  <= CNT_ONE;
                    end else begin
                        stab_q  <= CNT_ZERO;
                    end
                end
                ARM_R: begin
                    if (pressed_s) begin
                        state_q <= PRS;
                        stab_q  <= CNT_ZERO;
                    end else if (release_evt_s) begin
                        state_q   <= REL;
                        stab_q    <= CNT_ZERO;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        stab_q    <= stab_d;
                    end
                end
                default: begin
                    state_q <= REL;
                    stab_q  <= CNT_ZERO;
                    level_q <= 1'b0;
                end
            endcase

            // Hold timing runs only while the debounced level is high. The
            // release cycle clears it instead of counting, so long_stb can
            // never coincide with release_stb.
            if (press_evt_s || release_evt_s) begin
                hold_q      <= CNT_ZERO;
                long_done_q <= 1'b0;
            end else if (level_q) begin
                hold_q <= hold_d;
                if ((hold_q == HOLD_LAST) && !long_done_q) begin
                    long_q      <= 1'b1;
                    long_done_q <= 1'b1;
                end else begin
                    long_done_q <= long_done_q;
                end
            end else begin
                hold_q <= CNT_ZERO;
            end
        end
    end

    assign btn_level   = level_q;
    assign press_stb   = press_q;
    assign release_stb = release_q;
    assign long_stb    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
// Randomised + scenario-driven bench. A reference model predicts accepted
// events from the run length of stable samples; a monitor pops predictions
// whenever the DUT raises a strobe and compares kind and cycle.
// -----------------------------------------------------------------------------
module tb_key_debounce;

    localparam int STABLE = 4;
    localparam int LONG   = 20;

    localparam int K_PRESS = 1;
    localparam int K_REL   = 2;
    localparam int K_LONG  = 4;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic btn_in = 1'b0;
    logic btn_level;
    logic press_stb;
    logic release_stb;
    logic long_stb;

    always #5 clk = ~clk;

    key_debounce #(
        .STABLE_CYCLES (STABLE),
        .LONG_CYCLES   (LONG),
        .ACTIVE_LOW    (1'b1),
        .CNT_W         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .press_stb   (press_stb),
        .release_stb (release_stb),
        .long_stb    (long_stb)
    );

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;

    // Reference model state: pressed-sense samples in a 2-deep delay line,
    // current accepted level, length of the current run of opposite samples.
    bit  m_d1 = 1'b0;
    bit  m_d2 = 1'b0;
    int  m_level = 0;
    int  m_run = 0;
    int  m_press_cyc = 0;
    bit  m_long_pending = 1'b0;

    task automatic push_ev(input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Model: a new level is accepted after STABLE consecutive synchronised
    // samples disagree with the current level; a long event follows LONG
    // cycles after the press if no release was accepted by then.
    initial begin
        bit seen;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_d1 = 1'b0;
                m_d2 = 1'b0;
                m_level = 0;
                m_run = 0;
                m_long_pending = 1'b0;
            end else begin
                seen = m_d2;
                m_d2 = m_d1;
                m_d1 = ~btn_in;
                if (int'(seen) != m_level) begin
                    m_run++;
                    if (m_run == STABLE) begin
                        m_level = int'(seen);
                        m_run = 0;
                        if (seen) begin
                            push_ev(K_PRESS, cyc);
                            m_press_cyc = cyc;
                            m_long_pending = 1'b1;
                        end else begin
                            push_ev(K_REL, cyc);
                            m_long_pending = 1'b0;
                        end
                    end
                end else begin
                    m_run = 0;
                end
                if (m_long_pending && m_level == 1 && (cyc - m_press_cyc) == LONG) begin
                    push_ev(K_LONG, cyc);
                    m_long_pending = 1'b0;
                end
            end
        end
    end

    // Monitor: level every cycle, strobes against the scoreboard queue.
    initial begin
        int mask;
        ev_t e;
        forever begin
            @(negedge clk);
            checks++;
            if (btn_level !== (m_level == 1)) begin
                errors++;
                $display("FAIL level cyc=%0d got=%b want=%0d", cyc, btn_level, m_level);
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event kind=%0d want_cyc=%0d now=%0d", e.kind, e.cyc, cyc);
            end
            mask = int'({long_stb, release_stb, press_stb});
            if (mask != 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe cyc=%0d got_mask=%0d want=none", cyc, mask);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != mask || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL strobe got_mask=%0d@%0d want_kind=%0d@%0d",
                                 mask, cyc, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input int n);
        btn_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Stimulus: test-plan scenarios followed by random bouncing segments.
    initial begin
        int n;
        logic v;
        // Reset with the button held pressed.
        rst = 1'b1;
        btn_in = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if ({btn_level, press_stb, release_stb, long_stb} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=0000",
                     {btn_level, press_stb, release_stb, long_stb});
        end
        rst = 1'b0;
        // Press held through reset release, long hold, then clean release.
        drive(1'b0, 30);
        drive(1'b1, 15);
        // Bouncing press, then held.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 2);
            drive(1'b1, 2);
        end
        drive(1'b0, 30);
        // Bouncy release after a long hold.
        drive(1'b1, 1);
        drive(1'b0, 1);
        drive(1'b1, 20);
        // Short hold with bouncy release: no long event expected.
        drive(1'b0, 12);
        drive(1'b1, 1);
        drive(1'b0, 1);
        drive(1'b1, 20);
        // Press shorter than the debounce window.
        drive(1'b0, 3);
        drive(1'b1, 15);
        // Async reset while arming a release.
        drive(1'b0, 15);
        btn_in = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({btn_level, press_stb, release_stb, long_stb} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset got=%b want=0000",
                     {btn_level, press_stb, release_stb, long_stb});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 15);
        // Random bouncing segments.
        for (int i = 0; i < 40; i++) begin
            v = logic'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                n = int'($urandom_range(10, 30));
            end else begin
                n = int'($urandom_range(1, 6));
            end
            drive(v, n);
        end
        drive(1'b1, 40);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
